cp0_ctrl: RTL

- Coprocessor-0 block inside the CPU. It consumes the 6-bit HWInt vector produced by the bridge (timer IRQs and the external interrupt) and the exception code of the instruction in M stage.
- Holds SR, Cause and EPC.
- Raises a single request, Req, that makes the pipeline flush and redirect to the handler.
- Serves mfc0/mtc0 accesses and supplies the return address for eret.

---
 rtl/cp0_ctrl_pkg.sv | 29 ++
 rtl/cp0_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 constants: register numbers, field positions, exception codes, default addresses.
package cp0_ctrl_pkg;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam int SR_IE       = 0;
   localparam int SR_EXL      = 1;
   localparam int SR_IM_LO    = 10;
   localparam int SR_IM_HI    = 15;
   localparam int CAUSE_BD    = 31;
   localparam int CAUSE_IP_LO = 10;
   localparam int CAUSE_EC_LO = 2;

   typedef enum logic [4:0] {
      EXC_INT     = 5'd0,
      EXC_ADEL    = 5'd4,
      EXC_ADES    = 5'd5,
      EXC_SYSCALL = 5'd8,
      EXC_RI      = 5'd10,
      EXC_OV      = 5'd12
   } exc_code_e;

   localparam logic [31:0] EXC_ADDR_DEF   = 32'h0000_4180;
   localparam logic [31:0] PRID_VALUE_DEF = 32'h0000_4350;

endpackage

// File: rtl/cp0_ctrl.sv
// Coprocessor 0: SR/Cause/EPC, interrupt/exception request, mfc0/mtc0, eret return address.
// Optional macro CP0_PRID_EN makes reg 15 (PRId) read PRID_VALUE.
module cp0_ctrl
   import cp0_ctrl_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE = PRID_VALUE_DEF,
   parameter logic [31:0] EXC_ADDR   = EXC_ADDR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] DOut,
   output logic [31:0] EPCOut,
   output logic [31:0] HandlerPC,
   output logic        Req
);

`ifdef CP0_PRID_EN
   localparam logic PRID_EN = 1'b1;
`else
   localparam logic PRID_EN = 1'b0;
`endif

   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exc_q, exc_d;
   logic [31:0] epc_q, epc_d;

   logic        int_req, exc_req;
   logic [31:0] sr_word, cause_word, prid_word;

   assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
   assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
   assign Req     = int_req | exc_req;

   assign sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
   assign cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
   assign prid_word  = PRID_VALUE & {32{PRID_EN}};

   always_comb begin
      DOut = 32'd0;
      case (A1)
         CP0_SR:    DOut = sr_word;
         CP0_CAUSE: DOut = cause_word;
         CP0_EPC:   DOut = epc_q;
         CP0_PRID:  DOut = prid_word;
         default:   DOut = 32'd0;
      endcase
   end

   assign EPCOut    = epc_q;
   assign HandlerPC = EXC_ADDR;

   always_comb begin
      im_d  = im_q;
      exl_d = exl_q;
      ie_d  = ie_q;
      bd_d  = bd_q;
      ip_d  = HWInt;
      exc_d = exc_q;
      epc_d = epc_q;
      if (Req) begin
         // Victim is cancelled, so any same-cycle mtc0 is dropped.
         exl_d = 1'b1;
         bd_d  = BDIn;
         exc_d = int_req ? EXC_INT : ExcCodeIn;
         epc_d = BDIn ? (VPC - 32'd4) : VPC;
      end else begin
         if (WE && A2 == CP0_SR) begin
            im_d  = DIn[SR_IM_HI:SR_IM_LO];
            exl_d = DIn[SR_EXL];
            ie_d  = DIn[SR_IE];
         end
         if (WE && A2 == CP0_EPC)
            epc_d = DIn & ~32'd3;
         if (EXLClr)
            exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im_q  <= 6'd0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         bd_q  <= 1'b0;
         ip_q  <= 6'd0;
         exc_q <= 5'd0;
         epc_q <= 32'd0;
      end else begin
         im_q  <= im_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         bd_q  <= bd_d;
         ip_q  <= ip_d;
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

endmodule
